// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared constants and next-PC select encoding for the PC sequencer
package pc_seq_pkg;
  localparam int ADDR_W = 19;
  localparam logic [ADDR_W-1:0] RESET_VEC = 19'h00000;
  localparam logic [ADDR_W-1:0] TRAP_VEC = 19'h7FFF0;
  typedef enum logic [2:0] {NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_CALL, NPC_RET} npc_sel_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder <-> PC sequencer bus
// master: decoder side, drives Stall/Branch/BrNe/Zero/Jump/Call/Ret/ImmExt
// slave: sequencer side, drives PC/PCPlus1/StackEmpty/StackFull/Overflow/Underflow/Trap
interface pc_sequencer_if #(parameter int ADDR_W = pc_seq_pkg::ADDR_W);
  logic Stall, Branch, BrNe, Zero, Jump, Call, Ret;
  logic [ADDR_W-1:0] ImmExt, PC, PCPlus1;
  logic StackEmpty, StackFull, Overflow, Underflow, Trap;
  modport master(
    output Stall, Branch, BrNe, Zero, Jump, Call, Ret, ImmExt,
    input PC, PCPlus1, StackEmpty, StackFull, Overflow, Underflow, Trap
  );
  modport slave(
    input Stall, Branch, BrNe, Zero, Jump, Call, Ret, ImmExt,
    output PC, PCPlus1, StackEmpty, StackFull, Overflow, Underflow, Trap
  );
endinterface

// File: rtl/return_stack.sv
// return_stack: DEPTH x W LIFO with asynchronous top-of-stack read
// ports: clk, rst_n (sync, active low), push_i, pop_i, wdata_i -> rdata_o, full_o, empty_o
// push while full and pop while empty are ignored; SP saturates at 0 and DEPTH
module return_stack #(
  parameter int DEPTH = 16,
  parameter int W = pc_seq_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  import pc_seq_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int SP_W = AW + 1;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;
  assign wr_idx = sp_q[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign rdata_o = mem_q[rd_idx];
  assign empty_o = sp_q == '0;
  assign full_o = sp_q == SP_W'(DEPTH);
  always_comb sp_d = (push_i && !full_o) ? sp_q + SP_W'(1) : (pop_i && !empty_o) ? sp_q - SP_W'(1) : sp_q;
  always_ff @(posedge clk)
    if (!rst_n) sp_q <= '0;
    else sp_q <= sp_d;
  always_ff @(posedge clk)
    if (rst_n && push_i && !full_o) mem_q[wr_idx] <= wdata_i;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side next-PC selection with hardware return-address stack
// ports: clk, rst_n (sync, active low), bus (pc_sequencer_if.slave)
// optional macro PC_SEQ_TRAP_EN: stack overflow/underflow redirects to TRAP_VEC and pulses Trap
module pc_sequencer #(
  parameter int ADDR_W = pc_seq_pkg::ADDR_W,
  parameter int DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = pc_seq_pkg::RESET_VEC,
  parameter logic [ADDR_W-1:0] TRAP_VEC = pc_seq_pkg::TRAP_VEC
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.slave bus
);
  import pc_seq_pkg::*;
  npc_sel_e sel;
  logic taken, ovf_set, unf_set, push, pop, full, empty;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, rdata;
  logic ovf_q, unf_q;
  return_stack #(.DEPTH(DEPTH), .W(ADDR_W)) u_stack (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .wdata_i(pc_inc),
    .rdata_o(rdata), .full_o(full), .empty_o(empty)
  );
  assign pc_inc = pc_q + ADDR_W'(1);
  always_comb begin
    taken = bus.Branch & (bus.Zero ^ bus.BrNe);
    sel = bus.Ret ? NPC_RET : bus.Call ? NPC_CALL : bus.Jump ? NPC_JUMP : taken ? NPC_BRANCH : NPC_SEQ;
    ovf_set = sel == NPC_CALL && full;
    unf_set = sel == NPC_RET && empty;
    push = !bus.Stall && sel == NPC_CALL;
    pop = !bus.Stall && sel == NPC_RET;
    pc_d = sel == NPC_RET ? (empty ? pc_inc : rdata) :
           (sel == NPC_CALL || sel == NPC_JUMP) ? bus.ImmExt :
           sel == NPC_BRANCH ? pc_q + bus.ImmExt : pc_inc;
`ifdef PC_SEQ_TRAP_EN
    if (ovf_set || unf_set) pc_d = TRAP_VEC;
`endif
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      pc_q <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!bus.Stall) begin
      pc_q <= pc_d;
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
`ifdef PC_SEQ_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk)
    if (!rst_n) trap_q <= 1'b0;
    else trap_q <= !bus.Stall && (ovf_set || unf_set);
  assign bus.Trap = trap_q & ~bus.Stall;
`else
  assign bus.Trap = 1'b0;
`endif
  assign bus.PC = pc_q;
  assign bus.PCPlus1 = pc_inc;
  assign bus.StackEmpty = empty;
  assign bus.StackFull = full;
  assign bus.Overflow = ovf_q;
  assign bus.Underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized checks against a queue-based reference model
module tb_pc_sequencer;
  import pc_seq_pkg::*;
  localparam int DEPTH = 16;
`ifdef PC_SEQ_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pc_sequencer_if bus();
  pc_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  logic [ADDR_W-1:0] m_pc = '0;
  logic [ADDR_W-1:0] m_stk[$];
  bit m_ovf = 1'b0, m_unf = 1'b0, m_err = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (armed) begin
      chk("pc", 32'(bus.PC), 32'(m_pc));
      chk("pcplus1", 32'(bus.PCPlus1), 32'(ADDR_W'(m_pc + ADDR_W'(1))));
      chk("empty", 32'(bus.StackEmpty), 32'(m_stk.size() == 0));
      chk("full", 32'(bus.StackFull), 32'(m_stk.size() == DEPTH));
      chk("overflow", 32'(bus.Overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.Underflow), 32'(m_unf));
      chk("trap", 32'(bus.Trap), 32'(TRAP_ON & m_err & !bus.Stall));
    end
  task automatic step(input bit rs, st, br, ne, z, j, c, r, input logic [ADDR_W-1:0] imm);
    logic [ADDR_W-1:0] nxt;
    rst_n = !rs;
    bus.Stall = st; bus.Branch = br; bus.BrNe = ne; bus.Zero = z;
    bus.Jump = j; bus.Call = c; bus.Ret = r; bus.ImmExt = imm;
    @(posedge clk);
    m_err = 1'b0;
    if (rs) begin
      m_pc = RESET_VEC; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!st) begin
      nxt = m_pc + ADDR_W'(1);
      if (r) begin
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
        else begin m_unf = 1'b1; m_err = 1'b1; end
      end else if (c) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(ADDR_W'(m_pc + ADDR_W'(1)));
        else begin m_ovf = 1'b1; m_err = 1'b1; end
        nxt = imm;
      end else if (j) nxt = imm;
      else if (br && (z != ne)) nxt = m_pc + imm;
      m_pc = (TRAP_ON && m_err) ? TRAP_VEC : nxt;
    end
    #1;
  endtask
  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, '0); endtask
  task automatic jmp(input logic [ADDR_W-1:0] a); step(0, 0, 0, 0, 0, 1, 0, 0, a); endtask
  task automatic call(input logic [ADDR_W-1:0] a); step(0, 0, 0, 0, 0, 1, 1, 0, a); endtask
  task automatic ret(); step(0, 0, 0, 0, 0, 1, 0, 1, '0); endtask
  initial begin
    logic [ADDR_W-1:0] imm;
    step(1, 0, 0, 0, 0, 0, 0, 0, '0);
    step(1, 0, 1, 0, 1, 1, 1, 0, 19'd77);
    armed = 1'b1;
    chk("rst_pc", 32'(bus.PC), 32'(RESET_VEC));
    chk("rst_empty", 32'(bus.StackEmpty), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk("idle_pc", 32'(bus.PC), 32'(k));
    end
    repeat (2) begin
      step(0, 1, 1, 0, 1, 1, 1, 0, 19'd55);
      chk("stall_pc", 32'(bus.PC), 32'd4);
    end
    jmp(19'd10); step(0, 0, 1, 0, 1, 0, 0, 0, 19'h7FFFC);
    chk("beq_taken", 32'(bus.PC), 32'd6);
    jmp(19'd10); step(0, 0, 1, 0, 0, 0, 0, 0, 19'h7FFFC);
    chk("beq_not_taken", 32'(bus.PC), 32'd11);
    jmp(19'd10); step(0, 0, 1, 1, 0, 0, 0, 0, 19'h7FFFC);
    chk("bne_taken", 32'(bus.PC), 32'd6);
    jmp(19'd20); call(19'd100);
    chk("call_pc", 32'(bus.PC), 32'd100);
    chk("call_not_empty", 32'(bus.StackEmpty), 32'd0);
    ret();
    chk("ret_pc", 32'(bus.PC), 32'd21);
    chk("ret_empty", 32'(bus.StackEmpty), 32'd1);
    jmp(19'd200);
    for (int i = 0; i < 16; i++) call(ADDR_W'(300 + i));
    chk("nest_full", 32'(bus.StackFull), 32'd1);
    call(19'd500);
    chk("ovf_pc", 32'(bus.PC), TRAP_ON ? 32'(TRAP_VEC) : 32'd500);
    chk("ovf_flag", 32'(bus.Overflow), 32'd1);
    chk("ovf_trap", 32'(bus.Trap), 32'(TRAP_ON));
    for (int k = 0; k < 16; k++) begin
      ret();
      chk("lifo_pc", 32'(bus.PC), k < 15 ? 32'(315 - k) : 32'd201);
    end
    chk("lifo_empty", 32'(bus.StackEmpty), 32'd1);
    jmp(19'd7); ret();
    chk("unf_pc", 32'(bus.PC), TRAP_ON ? 32'(TRAP_VEC) : 32'd8);
    chk("unf_flag", 32'(bus.Underflow), 32'd1);
    chk("unf_trap", 32'(bus.Trap), 32'(TRAP_ON));
    idle();
    chk("unf_sticky", 32'(bus.Underflow), 32'd1);
    chk("trap_one_cycle", 32'(bus.Trap), 32'd0);
    jmp(19'd30); step(1, 0, 0, 0, 0, 1, 1, 0, 19'd100);
    chk("rst_call_pc", 32'(bus.PC), 32'(RESET_VEC));
    chk("rst_call_empty", 32'(bus.StackEmpty), 32'd1);
    chk("rst_call_ovf", 32'(bus.Overflow), 32'd0);
    chk("rst_call_unf", 32'(bus.Underflow), 32'd0);
    for (int n = 0; n < 600; n++) begin
      imm = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 40) - 20);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, imm);
    end
    idle();
    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side program-counter stage sitting directly downstream of the main decoder.
- Consumes the decoder's Branch/Jump/Call/Ret strobes, the ALU Zero flag and the extended immediate, and produces the next instruction address for instruction memory.
- Contains a hardware return-address stack (LIFO) serving CALL/RET, so no architectural register or data memory is used for return addresses.

Parameters:
- ADDR_W, 19, PC / instruction address width in bits (word-addressed).
- DEPTH, 16, return-stack entries; power of two, minimum 2.
- RESET_VEC, 19'h00000, PC value after reset.
- TRAP_VEC, 19'h7FFF0, redirect target used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- Stall  input  1  1 = hold PC and stack, ignore all control inputs.
- Branch  input  1  conditional branch strobe from the decoder.
- BrNe  input  1  branch sense: 0 = BEQ (take on Zero=1), 1 = BNE (take on Zero=0).
- Zero  input  1  ALU zero flag for the current instruction.
- Jump  input  1  unconditional redirect strobe (also high with Call and Ret).
- Call  input  1  push return address, then jump.
- Ret  input  1  pop return address, then jump.
- ImmExt  input  ADDR_W  extended immediate: branch offset or jump/call target.
- PC  output  ADDR_W  registered current instruction address.
- PCPlus1  output  ADDR_W  combinational PC+1 (modulo 2^ADDR_W).
- StackEmpty  output  1  SP==0.
- StackFull  output  1  SP==DEPTH.
- Overflow  output  1  sticky; set on CALL while full.
- Underflow  output  1  sticky; set on RET while empty.
- Trap  output  1  one-cycle pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0 at posedge): PC=RESET_VEC, SP=0, Overflow=0, Underflow=0, Trap=0. Stack RAM contents are don't-care. Reset overrides Stall and all strobes, including mid-CALL/RET.
- Latency: strobes sampled in cycle N determine the PC at posedge ending cycle N; one PC per cycle, no bubbles.
- Stall=1: PC, SP and flags hold. Trap is 0 during a stall.
- Next-PC priority, highest first:
  - Ret: pop.
  - Call: push.
  - Jump: PC<=ImmExt (absolute).
  - Branch taken: PC<=PC+ImmExt (two's complement, mod 2^ADDR_W).
  - Otherwise: PC<=PCPlus1.
- Branch taken = Branch & (Zero ^ BrNe). Branch together with Jump/Call/Ret is ignored.
- CALL, not full: stack[SP]<=PCPlus1, SP<=SP+1, PC<=ImmExt.
- CALL, full: no write, SP unchanged, Overflow<=1, PC<=ImmExt.
- RET, not empty: SP<=SP-1, PC<=stack[SP-1].
- RET, empty: SP unchanged, Underflow<=1, PC<=PCPlus1.
- Call and Ret both high (illegal encoding): Ret wins; Call is ignored, with no push.
- SP width is clog2(DEPTH)+1. It never wraps; saturates at 0 and DEPTH.
- Stack read is asynchronous (LUT RAM) so RET needs no extra cycle.

Optional Feature:
- Macro PC_SEQ_TRAP_EN.
- Defined: a CALL-while-full or RET-while-empty forces PC<=TRAP_VEC instead of the target above, and Trap pulses high for exactly that cycle. Sticky flags still set.
- Undefined: behaviour as above; Trap is constant 0.

Decomposition:
- Package pc_seq_pkg holds:
  - ADDR_W constant;
  - next-PC select enum {NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_CALL, NPC_RET};
  - default RESET_VEC and TRAP_VEC.
- Sub-module return_stack: DEPTH x ADDR_W LIFO with push/pop, SP, full/empty. pc_sequencer owns priority, PC register and flags.

Test Plan:
- Reset then 4 idle cycles -> PC 0,1,2,3,4. Stall high for 2 cycles at PC=4 -> PC held at 4.
- PC=10, Branch=1, BrNe=0, Zero=1, ImmExt=19'h7FFFC (-4) -> PC=6. Same with Zero=0 -> PC=11. BrNe=1, Zero=0 -> PC=6.
- PC=20, Call+Jump, ImmExt=100 -> PC=100, SP=1, stack[0]=21. At 100, Ret+Jump -> PC=21, SP=0, StackEmpty=1.
- 16 nested CALLs -> StackFull=1. 17th CALL to 500 -> PC=500, Overflow=1, SP=16. Then 16 RETs return the correct addresses in LIFO order.
- RET with SP=0 at PC=7 -> PC=8, Underflow=1 sticky. With PC_SEQ_TRAP_EN -> PC=TRAP_VEC, Trap high 1 cycle.
- rst_n low during a CALL cycle at PC=30 -> PC=RESET_VEC, SP=0, flags cleared, no push.
